// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add RV64 MUL controller that borrows the shared EX ALU.
// Returns the low WIDTH bits of op_a*op_b through valid/ready handshakes.
module alu_mul_sequencer #(
  parameter int WIDTH      = 64,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_result = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = 4'b0000;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt    = '0;
          mcand_nxt  = op_a;
          mplier_nxt = op_b;
          cnt_nxt    = '0;
          // a zero multiplier needs no ALU work at all
          if (EARLY_EXIT && op_b == '0)
            state_nxt = DONE;
          else
            state_nxt = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        alu_a  = acc;
        alu_b  = mcand;
        alu_op = 4'b0010;
        if (mplier[0])
          acc_nxt = alu_result;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 1'b1;
        // stop once no set multiplier bits remain above this one
        if (cnt == LAST || (EARLY_EXIT && mplier[WIDTH-1:1] == '0))
          state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_result = acc;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer, both EARLY_EXIT settings.
// A behavioural ALU closes the loop on each instance.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;

  logic        in_valid_e = 1'b0, out_ready_e = 1'b0;
  logic        in_ready_e, out_valid_e, busy_e;
  logic [63:0] out_result_e, alu_a_e, alu_b_e, alu_result_e;
  logic [3:0]  alu_op_e;

  logic        in_valid_f = 1'b0, out_ready_f = 1'b0;
  logic        in_ready_f, out_valid_f, busy_f;
  logic [63:0] out_result_f, alu_a_f, alu_b_f, alu_result_f;
  logic [3:0]  alu_op_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input logic [3:0]  op);
    logic [63:0] x, y;
    x = op[3] ? ~a : a;
    y = op[2] ? ~b : b;
    case (op[1:0])
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x + y;
      default: return '0;
    endcase
  endfunction

  assign alu_result_e = alu(alu_a_e, alu_b_e, alu_op_e);
  assign alu_result_f = alu(alu_a_f, alu_b_f, alu_op_f);

  alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b1)) u_e (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_e), .in_ready(in_ready_e),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid_e), .out_ready(out_ready_e),
    .out_result(out_result_e), .busy(busy_e),
    .alu_a(alu_a_e), .alu_b(alu_b_e), .alu_op(alu_op_e),
    .alu_result(alu_result_e)
  );

  alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b0)) u_f (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_f), .in_ready(in_ready_f),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid_f), .out_ready(out_ready_f),
    .out_result(out_result_f), .busy(busy_f),
    .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_op(alu_op_f),
    .alu_result(alu_result_f)
  );

  // Offers one operand pair in the current cycle (T) and waits for out_valid.
  // lat is the number of cycles after T at which out_valid is first seen.
  task automatic do_op(input bit early, input logic [63:0] a,
                       input logic [63:0] b, output int lat,
                       output logic [63:0] res, output int adds);
    lat  = -1;
    adds = 0;
    res  = '0;
    op_a = a;
    op_b = b;
    if (early) in_valid_e = 1'b1;
    else       in_valid_f = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      in_valid_e = 1'b0;
      in_valid_f = 1'b0;
      if ((early ? alu_op_e : alu_op_f) == 4'b0010) adds++;
      if (early ? out_valid_e : out_valid_f) begin
        lat = i;
        res = early ? out_result_e : out_result_f;
        break;
      end
    end
  endtask

  task automatic finish_op(input bit early);
    if (early) out_ready_e = 1'b1;
    else       out_ready_f = 1'b1;
    @(negedge clk);
    out_ready_e = 1'b0;
    out_ready_f = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready_e, out_valid_e, busy_e, alu_op_e} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctl_e got=%b exp=1000000",
               {in_ready_e, out_valid_e, busy_e, alu_op_e});
    end
    checks++;
    if ({out_result_e, alu_a_e, alu_b_e} !== '0) begin
      failures++;
      $display("FAIL reset_data_e got=%h/%h/%h exp=0",
               out_result_e, alu_a_e, alu_b_e);
    end
    checks++;
    if ({in_ready_f, out_valid_f, busy_f, alu_op_f} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctl_f got=%b exp=1000000",
               {in_ready_f, out_valid_f, busy_f, alu_op_f});
    end
    checks++;
    if ({out_result_f, alu_a_f, alu_b_f} !== '0) begin
      failures++;
      $display("FAIL reset_data_f got=%h/%h/%h exp=0",
               out_result_f, alu_a_f, alu_b_f);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency_full();
    int lat, adds;
    logic [63:0] res;
    do_op(1'b0, 64'd3, 64'd5, lat, res, adds);
    checks++;
    if (lat !== 65) begin
      failures++;
      $display("FAIL full_latency got=%0d exp=65", lat);
    end
    checks++;
    if (res !== 64'd15) begin
      failures++;
      $display("FAIL full_result got=%0d exp=15", res);
    end
    checks++;
    if (adds !== 64) begin
      failures++;
      $display("FAIL full_add_cycles got=%0d exp=64", adds);
    end
    finish_op(1'b0);
    checks++;
    if ({in_ready_f, busy_f, out_valid_f} !== 3'b100) begin
      failures++;
      $display("FAIL full_idle_after got=%b exp=100",
               {in_ready_f, busy_f, out_valid_f});
    end
  endtask

  task automatic test_early_exit();
    int lat, adds;
    logic [63:0] res;
    do_op(1'b1, 64'd9, 64'd0, lat, res, adds);
    checks++;
    if (lat !== 1 || res !== 64'd0 || adds !== 0) begin
      failures++;
      $display("FAIL ee_zero got lat=%0d res=%0h adds=%0d exp lat=1 res=0 adds=0",
               lat, res, adds);
    end
    finish_op(1'b1);
    do_op(1'b1, 64'd7, 64'd1, lat, res, adds);
    checks++;
    if (lat !== 2 || res !== 64'd7 || adds !== 1) begin
      failures++;
      $display("FAIL ee_one got lat=%0d res=%0h adds=%0d exp lat=2 res=7 adds=1",
               lat, res, adds);
    end
    finish_op(1'b1);
    do_op(1'b1, 64'd5, 64'h8000_0000_0000_0000, lat, res, adds);
    checks++;
    if (lat !== 65 || res !== 64'h8000_0000_0000_0000) begin
      failures++;
      $display("FAIL ee_msb got lat=%0d res=%h exp lat=65 res=8000000000000000",
               lat, res);
    end
    finish_op(1'b1);
  endtask

  task automatic test_wrap();
    int lat, adds;
    logic [63:0] res;
    do_op(1'b1, '1, '1, lat, res, adds);
    checks++;
    if (res !== 64'd1 || lat !== 65) begin
      failures++;
      $display("FAIL wrap_ones_e got res=%h lat=%0d exp res=1 lat=65", res, lat);
    end
    finish_op(1'b1);
    do_op(1'b0, '1, '1, lat, res, adds);
    checks++;
    if (res !== 64'd1) begin
      failures++;
      $display("FAIL wrap_ones_f got=%h exp=1", res);
    end
    finish_op(1'b0);
    do_op(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, lat, res, adds);
    checks++;
    if (res !== 64'd0 || lat !== 34) begin
      failures++;
      $display("FAIL wrap_2p32 got res=%h lat=%0d exp res=0 lat=34", res, lat);
    end
    finish_op(1'b1);
  endtask

  task automatic test_backpressure();
    int lat, adds;
    logic [63:0] res;
    do_op(1'b1, 64'd9, 64'd11, lat, res, adds);
    checks++;
    if (res !== 64'd99 || lat !== 5) begin
      failures++;
      $display("FAIL bp_first got res=%0d lat=%0d exp res=99 lat=5", res, lat);
    end
    in_valid_e = 1'b1;
    op_a = 64'h55;
    op_b = 64'h3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid_e, in_ready_e, busy_e} !== 3'b101 ||
          out_result_e !== 64'd99) begin
        failures++;
        $display("FAIL bp_hold%0d got vrb=%b res=%0d exp vrb=101 res=99",
                 i, {out_valid_e, in_ready_e, busy_e}, out_result_e);
      end
    end
    out_ready_e = 1'b1;
    @(negedge clk);
    out_ready_e = 1'b0;
    checks++;
    if ({in_ready_e, busy_e, out_valid_e} !== 3'b100) begin
      failures++;
      $display("FAIL bp_release got=%b exp=100",
               {in_ready_e, busy_e, out_valid_e});
    end
    in_valid_e = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready_e, busy_e, out_valid_e} !== 3'b100) begin
      failures++;
      $display("FAIL bp_no_accept got=%b exp=100",
               {in_ready_e, busy_e, out_valid_e});
    end
  endtask

  task automatic test_abort(input bit use_flush);
    int lat, adds;
    logic [63:0] res;
    bit seen;
    op_a = 64'd3;
    op_b = 64'd5;
    in_valid_f = 1'b1;
    @(negedge clk);
    in_valid_f = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (busy_f !== 1'b1 || alu_op_f !== 4'b0010) begin
      failures++;
      $display("FAIL abort_run%0d got busy=%b op=%b exp busy=1 op=0010",
               use_flush, busy_f, alu_op_f);
    end
    if (use_flush) flush = 1'b1;
    else           reset = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    reset = 1'b0;
    checks++;
    if ({in_ready_f, out_valid_f, busy_f, alu_op_f} !== 7'b1000000) begin
      failures++;
      $display("FAIL abort_idle%0d got=%b exp=1000000", use_flush,
               {in_ready_f, out_valid_f, busy_f, alu_op_f});
    end
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid_f) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_valid%0d got=%b exp=0", use_flush, seen);
    end
    do_op(1'b0, 64'd6, 64'd7, lat, res, adds);
    checks++;
    if (res !== 64'd42 || lat !== 65) begin
      failures++;
      $display("FAIL abort_next%0d got res=%0d lat=%0d exp res=42 lat=65",
               use_flush, res, lat);
    end
    finish_op(1'b0);
  endtask

  task automatic test_flush_priority();
    int lat, adds;
    logic [63:0] res;
    in_valid_e = 1'b1;
    op_a = 64'd4;
    op_b = 64'd4;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid_e = 1'b0;
    checks++;
    if ({in_ready_e, busy_e} !== 2'b10) begin
      failures++;
      $display("FAIL flush_vs_valid got=%b exp=10", {in_ready_e, busy_e});
    end
    do_op(1'b1, 64'd2, 64'd3, lat, res, adds);
    checks++;
    if (res !== 64'd6 || lat !== 3) begin
      failures++;
      $display("FAIL flush_pre got res=%0d lat=%0d exp res=6 lat=3", res, lat);
    end
    flush = 1'b1;
    out_ready_e = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready_e = 1'b0;
    checks++;
    if ({in_ready_e, busy_e, out_valid_e} !== 3'b100 || out_result_e !== '0) begin
      failures++;
      $display("FAIL flush_drop got=%b res=%h exp=100 res=0",
               {in_ready_e, busy_e, out_valid_e}, out_result_e);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pa[20];
    logic [63:0] pb[20];
    logic [63:0] q[$];
    logic [63:0] exp, prod;
    int issued, got;
    bit acc_flag, bad;
    issued = 0;
    got = 0;
    acc_flag = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pa[i] = {$urandom, $urandom};
      pb[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
    end
    pb[3] = '0;
    pa[5] = '1;
    pb[5] = '1;
    out_ready_e = 1'b1;
    for (int cyc = 0; cyc < 4000 && got < 20; cyc++) begin
      @(negedge clk);
      if (acc_flag) begin
        issued++;
        acc_flag = 1'b0;
      end
      if (in_ready_e && busy_e) bad = 1'b1;
      if (out_valid_e) begin
        exp = 'x;
        if (q.size() != 0) exp = q.pop_front();
        checks++;
        if (out_result_e !== exp) begin
          failures++;
          $display("FAIL b2b_result%0d got=%h exp=%h", got, out_result_e, exp);
        end
        got++;
      end
      if (issued < 20) begin
        op_a = pa[issued];
        op_b = pb[issued];
        in_valid_e = 1'b1;
      end else begin
        in_valid_e = 1'b0;
      end
      if (in_ready_e && in_valid_e) begin
        prod = pa[issued] * pb[issued];
        q.push_back(prod);
        acc_flag = 1'b1;
      end
    end
    in_valid_e = 1'b0;
    out_ready_e = 1'b0;
    checks++;
    if (got !== 20 || q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d left=%0d exp=20 left=0", got, q.size());
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_busy got=%b exp=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_latency_full();
    test_early_exit();
    test_wrap();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
